// File: rtl/amci_pkg.sv
// Shared definitions for the AMCI command sequencer: FSM encoding, AXI response codes,
// and the bit layout of a queued command word {rnw, addr, wdata, tag}.
package amci_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ISSUE = 2'd1;
   localparam logic [1:0] WAIT  = 2'd2;
   localparam logic [1:0] RESP  = 2'd3;

   typedef enum logic [1:0] {
      ST_IDLE  = IDLE,
      ST_ISSUE = ISSUE,
      ST_WAIT  = WAIT,
      ST_RESP  = RESP
   } seq_state_e;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;
   localparam logic [1:0] DECERR = 2'b11;

   // The tag sits at the bottom of the word; the other fields stack above it.
   localparam int CMD_TAG_LSB = 0;

   function automatic int cmd_wdata_lsb(input int tw);
      return tw;
   endfunction

   function automatic int cmd_addr_lsb(input int dw, input int tw);
      return tw + dw;
   endfunction

   function automatic int cmd_rnw_bit(input int aw, input int dw, input int tw);
      return tw + dw + aw;
   endfunction

endpackage

// File: rtl/amci_cmd_fifo.sv
// Generic synchronous first-word-fall-through FIFO with registered ready/empty flags
// and an occupancy output. DEPTH must be a power of two, at least 2.
module amci_cmd_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   output logic                     ready,
   input  logic                     pop,
   output logic [WIDTH-1:0]         pop_data,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_LEVEL = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wptr;
   logic [PW-1:0]    rptr;
   logic [PW:0]      cnt;
   logic [PW:0]      cnt_next;
   logic             do_push;
   logic             do_pop;

   assign do_push = push & ready;
   assign do_pop  = pop & ~empty;

   always_comb begin
      cnt_next = cnt;
      if (do_push && !do_pop) cnt_next = cnt + 1'b1;
      else if (!do_push && do_pop) cnt_next = cnt - 1'b1;
   end

   // Flags are computed from the next occupancy so they are flops, never paths from push/pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         wptr  <= '0;
         rptr  <= '0;
         cnt   <= '0;
         ready <= 1'b0;
         empty <= 1'b1;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop)  rptr <= rptr + 1'b1;
         cnt   <= cnt_next;
         ready <= (cnt_next != FULL_LEVEL);
         empty <= (cnt_next == '0);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wptr] <= push_data;
   end

   assign pop_data = mem[rptr];
   assign level    = cnt;

endmodule

// File: rtl/amci_cmd_sequencer.sv
// Queues tagged register commands and issues them one at a time to an AXI4-Lite master's
// AMCI port, returning each completion on a response stream. The master's resetn is ~reset.
module amci_cmd_sequencer
   import amci_pkg::*;
#(
   parameter int DW         = 32,
   parameter int AW         = 32,
   parameter int TW         = 8,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          CMD_VALID,
   output logic                          CMD_READY,
   input  logic                          CMD_RNW,
   input  logic [AW-1:0]                 CMD_ADDR,
   input  logic [DW-1:0]                 CMD_WDATA,
   input  logic [TW-1:0]                 CMD_TAG,
   output logic [$clog2(FIFO_DEPTH):0]   CMD_LEVEL,
   output logic                          RSP_VALID,
   input  logic                          RSP_READY,
   output logic                          RSP_RNW,
   output logic [TW-1:0]                 RSP_TAG,
   output logic [DW-1:0]                 RSP_RDATA,
   output logic [1:0]                    RSP_RESP,
   output logic [AW-1:0]                 AMCI_WADDR,
   output logic [DW-1:0]                 AMCI_WDATA,
   output logic                          AMCI_WRITE,
   input  logic [1:0]                    AMCI_WRESP,
   input  logic                          AMCI_WIDLE,
   output logic [AW-1:0]                 AMCI_RADDR,
   output logic                          AMCI_READ,
   input  logic [DW-1:0]                 AMCI_RDATA,
   input  logic [1:0]                    AMCI_RRESP,
   input  logic                          AMCI_RIDLE,
   output logic [1:0]                    debug_state
);

   localparam int CW        = 1 + AW + DW + TW;
   localparam int WDATA_LSB = cmd_wdata_lsb(TW);
   localparam int ADDR_LSB  = cmd_addr_lsb(DW, TW);
   localparam int RNW_BIT   = cmd_rnw_bit(AW, DW, TW);

   seq_state_e        state;
   logic [CW-1:0]     head;
   logic              fifo_empty;
   logic              fifo_pop;
   logic              issue_rnw;
   logic [TW-1:0]     issue_tag;
   logic              head_rnw;
   logic [AW-1:0]     head_addr;
   logic [DW-1:0]     head_wdata;
   logic [TW-1:0]     head_tag;

   amci_cmd_fifo #(
      .WIDTH (CW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (CMD_VALID),
      .push_data ({CMD_RNW, CMD_ADDR, CMD_WDATA, CMD_TAG}),
      .ready     (CMD_READY),
      .pop       (fifo_pop),
      .pop_data  (head),
      .empty     (fifo_empty),
      .level     (CMD_LEVEL)
   );

   assign head_rnw   = head[RNW_BIT];
   assign head_addr  = head[ADDR_LSB +: AW];
   assign head_wdata = head[WDATA_LSB +: DW];
   assign head_tag   = head[CMD_TAG_LSB +: TW];

   // Both idles are required so a master left busy across a sequencer-only reset is not re-issued.
   assign fifo_pop    = (state == ST_IDLE) && !fifo_empty && AMCI_WIDLE && AMCI_RIDLE;
   assign debug_state = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= ST_IDLE;
         issue_rnw  <= 1'b0;
         issue_tag  <= '0;
         AMCI_WADDR <= '0;
         AMCI_WDATA <= '0;
         AMCI_RADDR <= '0;
         AMCI_WRITE <= 1'b0;
         AMCI_READ  <= 1'b0;
         RSP_VALID  <= 1'b0;
         RSP_RNW    <= 1'b0;
         RSP_TAG    <= '0;
         RSP_RDATA  <= '0;
         RSP_RESP   <= OKAY;
      end else begin
         case (state)
            ST_IDLE: begin
               if (fifo_pop) begin
                  issue_rnw <= head_rnw;
                  issue_tag <= head_tag;
                  if (head_rnw) begin
                     AMCI_RADDR <= head_addr;
                     AMCI_READ  <= 1'b1;
                  end else begin
                     AMCI_WADDR <= head_addr;
                     AMCI_WDATA <= head_wdata;
                     AMCI_WRITE <= 1'b1;
                  end
                  state <= ST_ISSUE;
               end
            end
            ST_ISSUE: begin
               AMCI_WRITE <= 1'b0;
               AMCI_READ  <= 1'b0;
               state      <= ST_WAIT;
            end
            ST_WAIT: begin
               if (issue_rnw ? AMCI_RIDLE : AMCI_WIDLE) begin
                  RSP_VALID <= 1'b1;
                  RSP_RNW   <= issue_rnw;
                  RSP_TAG   <= issue_tag;
                  RSP_RDATA <= issue_rnw ? AMCI_RDATA : '0;
                  RSP_RESP  <= issue_rnw ? AMCI_RRESP : AMCI_WRESP;
                  state     <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (RSP_READY) begin
                  RSP_VALID <= 1'b0;
                  state     <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_amci_cmd_sequencer.sv
// Directed bench for amci_cmd_sequencer with a behavioural AMCI master of programmable
// latency and response.
module tb_amci_cmd_sequencer;
   import amci_pkg::*;

   localparam int DW = 32;
   localparam int AW = 32;
   localparam int TW = 8;
   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   logic          CMD_VALID = 1'b0;
   logic          CMD_READY;
   logic          CMD_RNW = 1'b0;
   logic [AW-1:0] CMD_ADDR = '0;
   logic [DW-1:0] CMD_WDATA = '0;
   logic [TW-1:0] CMD_TAG = '0;
   logic [2:0]    CMD_LEVEL;
   logic          RSP_VALID;
   logic          RSP_READY = 1'b0;
   logic          RSP_RNW;
   logic [TW-1:0] RSP_TAG;
   logic [DW-1:0] RSP_RDATA;
   logic [1:0]    RSP_RESP;
   logic [AW-1:0] AMCI_WADDR;
   logic [DW-1:0] AMCI_WDATA;
   logic          AMCI_WRITE;
   logic [1:0]    AMCI_WRESP;
   logic          AMCI_WIDLE;
   logic [AW-1:0] AMCI_RADDR;
   logic          AMCI_READ;
   logic [DW-1:0] AMCI_RDATA;
   logic [1:0]    AMCI_RRESP;
   logic          AMCI_RIDLE;
   logic [1:0]    debug_state;

   amci_cmd_sequencer #(.DW(DW), .AW(AW), .TW(TW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY), .CMD_RNW(CMD_RNW),
      .CMD_ADDR(CMD_ADDR), .CMD_WDATA(CMD_WDATA), .CMD_TAG(CMD_TAG), .CMD_LEVEL(CMD_LEVEL),
      .RSP_VALID(RSP_VALID), .RSP_READY(RSP_READY), .RSP_RNW(RSP_RNW), .RSP_TAG(RSP_TAG),
      .RSP_RDATA(RSP_RDATA), .RSP_RESP(RSP_RESP),
      .AMCI_WADDR(AMCI_WADDR), .AMCI_WDATA(AMCI_WDATA), .AMCI_WRITE(AMCI_WRITE),
      .AMCI_WRESP(AMCI_WRESP), .AMCI_WIDLE(AMCI_WIDLE),
      .AMCI_RADDR(AMCI_RADDR), .AMCI_READ(AMCI_READ),
      .AMCI_RDATA(AMCI_RDATA), .AMCI_RRESP(AMCI_RRESP), .AMCI_RIDLE(AMCI_RIDLE),
      .debug_state(debug_state)
   );

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Master model: idle drops on the pulse and returns after m_lat cycles.
   int          m_lat = 3;
   logic [1:0]  m_bresp = OKAY;
   logic [1:0]  m_rresp = OKAY;
   logic [31:0] m_rdata = '0;
   logic        m_widle = 1'b1;
   logic        m_ridle = 1'b1;
   logic        hold_w = 1'b0;
   int          busy = 0;
   int          w_pulses = 0;
   int          r_pulses = 0;
   int          pulse_cyc = 0;

   assign AMCI_WIDLE = m_widle & ~hold_w;
   assign AMCI_RIDLE = m_ridle;
   assign AMCI_WRESP = m_bresp;
   assign AMCI_RRESP = m_rresp;
   assign AMCI_RDATA = m_rdata;

   always @(posedge clk) begin
      if (reset) begin
         m_widle <= 1'b1;
         m_ridle <= 1'b1;
         busy    <= 0;
      end else if (AMCI_WRITE || AMCI_READ) begin
         busy      <= m_lat;
         pulse_cyc <= cyc;
         if (AMCI_WRITE) begin
            m_widle  <= 1'b0;
            w_pulses <= w_pulses + 1;
         end
         if (AMCI_READ) begin
            m_ridle  <= 1'b0;
            r_pulses <= r_pulses + 1;
         end
      end else if (busy != 0) begin
         busy <= busy - 1;
         if (busy == 1) begin
            m_widle <= 1'b1;
            m_ridle <= 1'b1;
         end
      end
   end

   logic [TW-1:0] exp_q[$];

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      CMD_VALID = 1'b0;
      RSP_READY = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
   endtask

   // Called at a negedge; returns at the negedge after the accepting edge with VALID still high.
   task automatic push_cmd(input logic rnw, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [TW-1:0] tag, output int acc_cyc);
      int n = 0;
      CMD_VALID = 1'b1;
      CMD_RNW   = rnw;
      CMD_ADDR  = addr;
      CMD_WDATA = wdata;
      CMD_TAG   = tag;
      while (!CMD_READY && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!CMD_READY) begin
         errors++;
         $display("FAIL push_timeout: CMD_READY=%b after %0d cycles, want 1", CMD_READY, n);
         acc_cyc = -1;
         CMD_VALID = 1'b0;
      end else begin
         @(posedge clk);
         acc_cyc = cyc;
         @(negedge clk);
      end
   endtask

   task automatic wait_rsp();
      int n = 0;
      while (!RSP_VALID && n < 200) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (!RSP_VALID) begin
         errors++;
         $display("FAIL rsp_timeout: RSP_VALID=%b after %0d cycles, want 1", RSP_VALID, n);
      end
   endtask

   task automatic ack_rsp(output int hs_cyc);
      RSP_READY = 1'b1;
      @(posedge clk);
      hs_cyc = cyc;
      @(negedge clk);
      RSP_READY = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (CMD_READY !== 1'b0) begin errors++; $display("FAIL rst_ready: got %b want 0", CMD_READY); end
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid: got %b want 0", RSP_VALID); end
      checks++; if (CMD_LEVEL !== 3'd0) begin errors++; $display("FAIL rst_level: got %0d want 0", CMD_LEVEL); end
      checks++; if ({AMCI_WRITE, AMCI_READ} !== 2'b00) begin errors++; $display("FAIL rst_pulses: got %b want 00", {AMCI_WRITE, AMCI_READ}); end
      checks++; if ({AMCI_WADDR, AMCI_WDATA, AMCI_RADDR, RSP_TAG, RSP_RDATA} !== '0) begin errors++; $display("FAIL rst_data: outputs not zero"); end
      reset = 1'b0;
      @(negedge clk);
      checks++; if (CMD_READY !== 1'b1) begin errors++; $display("FAIL rst_exit_ready: got %b want 1", CMD_READY); end
      checks++; if (debug_state !== IDLE) begin errors++; $display("FAIL rst_state: got %0d want %0d", debug_state, IDLE); end
   endtask

   task automatic test_write();
      int acc, hs, w0;
      w0 = w_pulses;
      m_lat = 3; m_bresp = OKAY;
      push_cmd(1'b0, 32'h10, 32'hDEADBEEF, 8'h01, acc);
      CMD_VALID = 1'b0;
      wait_rsp();
      checks++; if (RSP_TAG !== 8'h01) begin errors++; $display("FAIL wr_tag: got %h want 01", RSP_TAG); end
      checks++; if (RSP_RNW !== 1'b0) begin errors++; $display("FAIL wr_rnw: got %b want 0", RSP_RNW); end
      checks++; if (RSP_RESP !== 2'b00) begin errors++; $display("FAIL wr_resp: got %b want 00", RSP_RESP); end
      checks++; if (RSP_RDATA !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", RSP_RDATA); end
      checks++; if (w_pulses - w0 !== 1) begin errors++; $display("FAIL wr_pulses: got %0d want 1", w_pulses - w0); end
      checks++; if (AMCI_WADDR !== 32'h10 || AMCI_WDATA !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_amci: got %h/%h want 10/deadbeef", AMCI_WADDR, AMCI_WDATA); end
      checks++; if (pulse_cyc - acc !== 2) begin errors++; $display("FAIL wr_latency: got %0d want 2", pulse_cyc - acc); end
      ack_rsp(hs);
      checks++; if (RSP_VALID !== 1'b0) begin errors++; $display("FAIL wr_rsp_drop: got %b want 0", RSP_VALID); end
   endtask

   task automatic test_read();
      int acc, hs, r0, w0;
      r0 = r_pulses; w0 = w_pulses;
      m_lat = 2; m_rdata = 32'h12345678; m_rresp = SLVERR;
      push_cmd(1'b1, 32'h20, 32'hFFFF0000, 8'h02, acc);
      CMD_VALID = 1'b0;
      wait_rsp();
      checks++; if (RSP_RDATA !== 32'h12345678) begin errors++; $display("FAIL rd_rdata: got %h want 12345678", RSP_RDATA); end
      checks++; if (RSP_RESP !== 2'b10) begin errors++; $display("FAIL rd_resp: got %b want 10", RSP_RESP); end
      checks++; if (RSP_TAG !== 8'h02 || RSP_RNW !== 1'b1) begin errors++; $display("FAIL rd_tag: got %h/%b want 02/1", RSP_TAG, RSP_RNW); end
      checks++; if (r_pulses - r0 !== 1 || w_pulses - w0 !== 0) begin errors++; $display("FAIL rd_pulses: got r%0d w%0d want r1 w0", r_pulses - r0, w_pulses - w0); end
      checks++; if (AMCI_RADDR !== 32'h20) begin errors++; $display("FAIL rd_raddr: got %h want 20", AMCI_RADDR); end
      ack_rsp(hs);
   endtask

   task automatic test_back_to_back();
      int acc0, acc, hs, w0;
      logic [TW-1:0] exp_tag;
      w0 = w_pulses;
      m_lat = 10; m_bresp = OKAY;
      for (int i = 0; i < 5; i++) begin
         push_cmd(1'b0, 32'h100 + 32'(i * 4), 32'hA0 + 32'(i), 8'(i), acc);
         if (i == 0) acc0 = acc;
         exp_q.push_back(8'(i));
      end
      CMD_VALID = 1'b0;
      checks++; if (acc - acc0 !== 4) begin errors++; $display("FAIL b2b_accept_span: got %0d want 4", acc - acc0); end
      checks++; if (CMD_READY !== 1'b0 || CMD_LEVEL !== 3'd4) begin errors++; $display("FAIL b2b_full: ready=%b level=%0d want 0/4", CMD_READY, CMD_LEVEL); end
      for (int k = 0; k < 5; k++) begin
         wait_rsp();
         exp_tag = exp_q.pop_front();
         checks++; if (RSP_TAG !== exp_tag) begin errors++; $display("FAIL b2b_tag: got %h want %h", RSP_TAG, exp_tag); end
         checks++; if (w_pulses - w0 !== k + 1) begin errors++; $display("FAIL b2b_pulses: got %0d want %0d", w_pulses - w0, k + 1); end
         ack_rsp(hs);
      end
      checks++; if (CMD_LEVEL !== 3'd0) begin errors++; $display("FAIL b2b_drain: got %0d want 0", CMD_LEVEL); end
   endtask

   task automatic test_rsp_backpressure();
      int acc, hs, w0;
      logic [TW-1:0] t0;
      logic [1:0] r0;
      logic [DW-1:0] d0;
      logic stable = 1'b1;
      w0 = w_pulses;
      m_lat = 2; m_bresp = SLVERR;
      push_cmd(1'b0, 32'h40, 32'h1111, 8'h30, acc);
      push_cmd(1'b0, 32'h44, 32'h2222, 8'h31, acc);
      CMD_VALID = 1'b0;
      wait_rsp();
      t0 = RSP_TAG; r0 = RSP_RESP; d0 = RSP_RDATA;
      checks++; if (t0 !== 8'h30 || r0 !== SLVERR) begin errors++; $display("FAIL bp_first: got %h/%b want 30/10", t0, r0); end
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (RSP_VALID !== 1'b1 || RSP_TAG !== t0 || RSP_RESP !== r0 || RSP_RDATA !== d0) stable = 1'b0;
      end
      checks++; if (stable !== 1'b1) begin errors++; $display("FAIL bp_stable: got %b want 1", stable); end
      checks++; if (w_pulses - w0 !== 1) begin errors++; $display("FAIL bp_no_issue: got %0d want 1", w_pulses - w0); end
      ack_rsp(hs);
      wait_rsp();
      checks++; if (pulse_cyc - hs !== 2) begin errors++; $display("FAIL bp_reissue: got %0d want 2", pulse_cyc - hs); end
      checks++; if (RSP_TAG !== 8'h31) begin errors++; $display("FAIL bp_second_tag: got %h want 31", RSP_TAG); end
      ack_rsp(hs);
   endtask

   task automatic test_widle_hold();
      int acc, hs, w0;
      hold_w = 1'b1;
      do_reset();
      w0 = w_pulses;
      m_lat = 3; m_bresp = OKAY;
      push_cmd(1'b0, 32'h50, 32'h5555, 8'h05, acc);
      CMD_VALID = 1'b0;
      repeat (10) @(negedge clk);
      checks++; if (w_pulses - w0 !== 0) begin errors++; $display("FAIL hold_no_pulse: got %0d want 0", w_pulses - w0); end
      checks++; if (CMD_LEVEL !== 3'd1) begin errors++; $display("FAIL hold_level: got %0d want 1", CMD_LEVEL); end
      hold_w = 1'b0;
      wait_rsp();
      checks++; if (w_pulses - w0 !== 1) begin errors++; $display("FAIL hold_one_pulse: got %0d want 1", w_pulses - w0); end
      checks++; if (RSP_TAG !== 8'h05) begin errors++; $display("FAIL hold_tag: got %h want 05", RSP_TAG); end
      ack_rsp(hs);
   endtask

   task automatic test_reset_in_wait();
      int acc, w0, n;
      logic seen = 1'b0;
      w0 = w_pulses;
      m_lat = 20;
      push_cmd(1'b0, 32'h60, 32'h6666, 8'h06, acc);
      push_cmd(1'b0, 32'h64, 32'h7777, 8'h07, acc);
      CMD_VALID = 1'b0;
      n = 0;
      while (w_pulses - w0 < 1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      repeat (3) @(negedge clk);
      checks++; if (debug_state !== WAIT || CMD_LEVEL !== 3'd1) begin errors++; $display("FAIL rw_pre: state=%0d level=%0d want %0d/1", debug_state, CMD_LEVEL, WAIT); end
      reset = 1'b1;
      repeat (2) @(negedge clk);
      checks++; if (RSP_VALID !== 1'b0 || CMD_LEVEL !== 3'd0) begin errors++; $display("FAIL rw_in_reset: valid=%b level=%0d want 0/0", RSP_VALID, CMD_LEVEL); end
      reset = 1'b0;
      RSP_READY = 1'b1;
      w0 = w_pulses;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (RSP_VALID) seen = 1'b1;
      end
      RSP_READY = 1'b0;
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rw_stale_rsp: got %b want 0", seen); end
      checks++; if (w_pulses - w0 !== 0) begin errors++; $display("FAIL rw_stale_issue: got %0d want 0", w_pulses - w0); end
      checks++; if (CMD_LEVEL !== 3'd0 || CMD_READY !== 1'b1) begin errors++; $display("FAIL rw_after: level=%0d ready=%b want 0/1", CMD_LEVEL, CMD_READY); end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_back_to_back();
      test_rsp_backpressure();
      test_widle_hold();
      test_reset_in_wait();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
